// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encoding, FSM states and shared helpers for the HI/LO unit
package muldiv_pkg;

  localparam int ITER = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [ITER-1:0] magnitude(input logic [ITER-1:0] v, input logic sgn);
    return (sgn && v[ITER-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int W = ITER
) (
  input  logic         mul,
  input  logic [W:0]   acc_hi,
  input  logic [W-1:0] acc_lo,
  input  logic [W-1:0] operand,
  output logic [W:0]   acc_hi_next,
  output logic [W-1:0] acc_lo_next
);

  logic [W:0]   sum;
  logic [W+1:0] trial;

  always_comb begin
    sum   = {1'b0, acc_hi[W-1:0]} + (acc_lo[0] ? {1'b0, operand} : '0);
    trial = {acc_hi, acc_lo[W-1]} - {2'b00, operand};
    if (mul) begin
      acc_hi_next = {1'b0, sum[W:1]};
      acc_lo_next = {sum[0], acc_lo[W-1:1]};
    end else begin
      // A borrow out of the trial subtraction means restore the shifted remainder.
      acc_lo_next = {acc_lo[W-2:0], ~trial[W+1]};
      acc_hi_next = trial[W+1] ? {acc_hi[W-1:0], acc_lo[W-1]} : trial[W:0];
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             rd_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_e             state, state_next;
  logic [CW-1:0]      counter;
  logic [WIDTH:0]     acc_hi, iter_hi;
  logic [WIDTH-1:0]   acc_lo, iter_lo, operand;
  logic               is_mul, neg_main, neg_rem;
  logic               load, step, finish, wr_hi, wr_lo;
  logic               arith_op, mul_op, signed_op;
  logic [WIDTH-1:0]   mag1, mag2, quotient, remainder;
  logic [2*WIDTH-1:0] product;

  assign mul_op    = (op == OP_MULT) || (op == OP_MULTU);
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign arith_op  = mul_op || (op == OP_DIV) || (op == OP_DIVU);
  assign mag1      = magnitude(op1, signed_op);
  assign mag2      = magnitude(op2, signed_op);

  assign busy  = (state != IDLE);
  assign stall = busy & (start | rd_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    case (state)
      IDLE: begin
        if (start && arith_op) begin
          load       = 1'b1;
          state_next = RUN;
        end else if (start) begin
          wr_hi = (op == OP_MTHI);
          wr_lo = (op == OP_MTLO);
        end
      end
      RUN: begin
        step = 1'b1;
        if (counter == '0) state_next = FIX;
      end
      FIX: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  muldiv_iter #(.W(WIDTH)) u_iter (
    .mul         (is_mul),
    .acc_hi      (acc_hi),
    .acc_lo      (acc_lo),
    .operand     (operand),
    .acc_hi_next (iter_hi),
    .acc_lo_next (iter_lo)
  );

  always_comb begin
    product   = {acc_hi[WIDTH-1:0], acc_lo};
    if (neg_main) product = -product;
    quotient  = neg_main ? -acc_lo : acc_lo;
    remainder = neg_rem ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter  <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      operand  <= '0;
      is_mul   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= finish;
      if (load) begin
        counter  <= CW'(WIDTH - 1);
        acc_hi   <= '0;
        is_mul   <= mul_op;
        acc_lo   <= mul_op ? mag2 : mag1;
        operand  <= mul_op ? mag1 : mag2;
        // A zero divisor leaves the all-ones quotient unsigned; the remainder sign still restores op1.
        neg_main <= signed_op && (op1[WIDTH-1] ^ op2[WIDTH-1]) && (mul_op || (op2 != '0));
        neg_rem  <= signed_op && op1[WIDTH-1];
      end else if (step) begin
        acc_hi <= iter_hi;
        acc_lo <= iter_lo;
        if (counter != '0) counter <= counter - 1'b1;
      end else if (finish) begin
        if (is_mul) begin
          hi <= product[2*WIDTH-1:WIDTH];
          lo <= product[WIDTH-1:0];
        end else begin
          hi <= remainder;
          lo <= quotient;
        end
      end
      if (wr_hi) hi <= op1;
      if (wr_lo) lo <= op1;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, rd_req;
  logic [2:0]  op;
  logic [31:0] op1, op2;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[10];

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .op1(op1), .op2(op2),
    .rd_req(rd_req), .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one op from IDLE; returns the number of busy cycles after the accepting edge.
  task automatic exec(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      output int lat, output logic dn);
    start = 1'b1; op = o; op1 = a; op2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (busy && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    dn = done;
  endtask

  function automatic logic is_arith(input logic [2:0] o);
    return o <= 3'd3;
  endfunction

  // Architectural reference: plain integer arithmetic on the operands.
  function automatic void ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] h, inout logic [31:0] l);
    longint      ps;
    logic [63:0] pu;
    int          sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      3'd0: begin ps = longint'(sa) * longint'(sb); {h, l} = ps; end
      3'd1: begin pu = {32'b0, a} * {32'b0, b}; {h, l} = pu; end
      3'd2: begin
        if (b == 0) begin h = a; l = 32'hFFFFFFFF; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin h = 0; l = 32'h80000000; end
        else begin l = sa / sb; h = sa % sb; end
      end
      3'd3: begin
        if (b == 0) begin h = a; l = 32'hFFFFFFFF; end
        else begin l = a / b; h = a % b; end
      end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          lat;
    logic        dn;
    logic [31:0] m_hi, m_lo;
    logic [2:0]  o;
    logic [31:0] a, b;

    vecs[0] = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[3] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[5] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[6] = '{OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[7] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[8] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[9] = '{OP_DIVU,  32'd9,        32'd3,        32'd0,        32'd3};

    reset = 1'b1; start = 1'b0; rd_req = 1'b0; op = 3'd0; op1 = '0; op2 = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    reset = 1'b0;
    rd_req = 1'b1; #1;
    chk("idle_rd_stall", stall, 0);
    rd_req = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      exec(vecs[i].op, vecs[i].a, vecs[i].b, lat, dn);
      chk($sformatf("vec%0d_latency", i), lat, 33);
      chk($sformatf("vec%0d_done", i), dn, 1);
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), done, 0);
    end

    exec(OP_MTHI, 32'h1234, 32'd0, lat, dn);
    chk("mthi_latency", lat, 0);
    chk("mthi_done", dn, 0);
    chk("mthi_hi", hi, 32'h1234);
    exec(OP_MTLO, 32'hABCD, 32'd0, lat, dn);
    chk("mtlo_done", dn, 0);
    chk("mtlo_lo", lo, 32'hABCD);
    chk("mtlo_hi_kept", hi, 32'h1234);
    exec(3'd6, 32'hDEAD, 32'hBEEF, lat, dn);
    chk("reserved_busy", lat, 0);
    chk("reserved_hi", hi, 32'h1234);
    chk("reserved_lo", lo, 32'hABCD);

    // DIV 1000/7 with an intruding MULT at E5 and rd_req from E10 on.
    start = 1'b1; op = OP_DIV; op1 = 32'd1000; op2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 33; e++) begin
      if (e == 5) begin start = 1'b1; op = OP_MULT; op1 = 32'd3; op2 = 32'd5; end
      if (e == 10) rd_req = 1'b1;
      #1;
      if (e == 5 || e >= 10) chk($sformatf("stall_e%0d", e), stall, 1);
      if (e == 32) chk("busy_before_e33", busy, 1);
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("window_done", done, 1);
    chk("window_busy", busy, 0);
    chk("window_stall_after", stall, 0);
    chk("window_hi", hi, 32'd6);
    chk("window_lo", lo, 32'd142);
    rd_req = 1'b0;
    exec(OP_MULT, 32'd3, 32'd5, lat, dn);
    chk("b2b_latency", lat, 33);
    chk("b2b_hi", hi, 32'd0);
    chk("b2b_lo", lo, 32'd15);

    // Asynchronous reset in the middle of a DIV.
    start = 1'b1; op = OP_DIV; op1 = 32'd1000; op2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_hi", hi, 0);
    chk("async_lo", lo, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done || busy) chk($sformatf("post_reset_quiet%0d", k), {done, busy}, 2'b00);
    end
    chk("post_reset_done", done, 0);
    exec(OP_DIVU, 32'd9, 32'd3, lat, dn);
    chk("after_reset_latency", lat, 33);
    chk("after_reset_hi", hi, 32'd0);
    chk("after_reset_lo", lo, 32'd3);

    m_hi = 32'd0;
    m_lo = 32'd3;
    for (int r = 0; r < 40; r++) begin
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      ref_op(o, a, b, m_hi, m_lo);
      exec(o, a, b, lat, dn);
      chk($sformatf("rnd%0d_op%0d_latency", r, o), lat, is_arith(o) ? 33 : 0);
      chk($sformatf("rnd%0d_op%0d_done", r, o), dn, is_arith(o));
      chk($sformatf("rnd%0d_op%0d_hi a=%h b=%h", r, o, a, b), hi, m_hi);
      chk($sformatf("rnd%0d_op%0d_lo a=%h b=%h", r, o, a, b), lo, m_lo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
